// File: rtl/soft_event_trig_multi_if.sv
// Soft-event trigger unit bus: event inputs, per-channel configuration and timing outputs.
// master drives events and configuration; slave is the trigger unit.
interface soft_event_trig_multi_if #(
    parameter int NCH     = 4,
    parameter int DLY_W   = 16,
    parameter int BURST_W = 8,
    parameter int TMO_W   = 24
);
    logic                   clk_enable;
    logic [NCH-1:0]         evg_soft_event;
    logic [NCH-1:0]         evg_trig;
    logic [NCH-1:0]         disarm;
    logic [NCH*DLY_W-1:0]   delay;
    logic [BURST_W-1:0]     burst_len;
    logic [TMO_W-1:0]       timeout;
    logic [NCH-1:0]         trig_out;
    logic [NCH-1:0]         armed;
    logic [NCH-1:0]         timeout_flag;

    modport master (
        output clk_enable, evg_soft_event, evg_trig, disarm, delay, burst_len, timeout,
        input  trig_out, armed, timeout_flag
    );

    modport slave (
        input  clk_enable, evg_soft_event, evg_trig, disarm, delay, burst_len, timeout,
        output trig_out, armed, timeout_flag
    );
endinterface

// File: rtl/soft_event_trig_multi.sv
// Per-channel soft-event arming: arm on soft event, fire trig_out after a delay on the next trigger rise.
// Latency: trigger rise sampled at edge k -> trig_out high after edge k+delay; soft event arms ~4 edges after sampling.
// No backpressure: events are level inputs; events arriving in a state that cannot use them are dropped.
module soft_event_trig_multi #(
    parameter int NCH     = 4,
    parameter int DLY_W   = 16,
    parameter int BURST_W = 8,
    parameter int TMO_W   = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    soft_event_trig_multi_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_FIRE  = 2'd3;

    logic [NCH-1:0] s1, s2, s3, sev_edge;
    logic [NCH-1:0] trig_q, trig_rise;

    // Synchroniser and trigger history run even while clk_enable is low so a held trigger never looks new.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            sev_edge <= '0;
            trig_q   <= '0;
        end else begin
            s1       <= bus.evg_soft_event;
            s2       <= s1;
            s3       <= s2;
            sev_edge <= s2 & ~s3;
            trig_q   <= bus.evg_trig;
        end
    end

    assign trig_rise = bus.evg_trig & ~trig_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [1:0]         state;
        logic [DLY_W-1:0]   dcnt;
        logic [BURST_W-1:0] rem;
        logic [TMO_W-1:0]   tmo_cnt;
        logic [TMO_W:0]     tmo_inc;
        logic [DLY_W-1:0]   dly_c;
        logic               fire_q;
        logic               flag_q;

        assign dly_c   = bus.delay[c*DLY_W +: DLY_W];
        assign tmo_inc = {1'b0, tmo_cnt} + (TMO_W+1)'(1);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= ST_IDLE;
                dcnt    <= '0;
                rem     <= '0;
                tmo_cnt <= '0;
                fire_q  <= 1'b0;
                flag_q  <= 1'b0;
            end else begin
                fire_q <= 1'b0;
                if (bus.disarm[c]) begin
                    state <= ST_IDLE;
                end else if (bus.clk_enable) begin
                    case (state)
                        ST_IDLE: begin
                            if (sev_edge[c]) begin
                                state   <= ST_ARMED;
                                tmo_cnt <= '0;
                                rem     <= bus.burst_len;
                                flag_q  <= 1'b0;
                            end
                        end
                        ST_ARMED: begin
                            // A trigger on the expiry edge still counts, so it is checked first.
                            if (trig_rise[c]) begin
                                if (dly_c == '0) begin
                                    state  <= ST_FIRE;
                                    fire_q <= 1'b1;
                                end else begin
                                    state <= ST_DELAY;
                                    dcnt  <= dly_c;
                                end
                            end else begin
                                tmo_cnt <= tmo_inc[TMO_W-1:0];
                                if (bus.timeout != '0 && tmo_inc == {1'b0, bus.timeout}) begin
                                    state  <= ST_IDLE;
                                    flag_q <= 1'b1;
                                end
                            end
                        end
                        ST_DELAY: begin
                            dcnt <= dcnt - DLY_W'(1);
                            if (dcnt == DLY_W'(1)) begin
                                state  <= ST_FIRE;
                                fire_q <= 1'b1;
                            end
                        end
                        ST_FIRE: begin
                            tmo_cnt <= '0;
                            if (rem == '0) begin
                                state <= ST_ARMED;
                            end else if (rem == BURST_W'(1)) begin
                                state <= ST_IDLE;
                            end else begin
                                rem   <= rem - BURST_W'(1);
                                state <= ST_ARMED;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end

        assign bus.trig_out[c]     = fire_q;
        assign bus.armed[c]        = (state != ST_IDLE);
        assign bus.timeout_flag[c] = flag_q;
    end
endmodule

// File: tb/tb_soft_event_trig_multi.sv
// Bench for soft_event_trig_multi: directed channel scenarios plus randomized trigger trains,
// with expected pulse times predicted on a cycle timeline from arm/burst/delay rules.
module tb_soft_event_trig_multi;
    localparam int NCH     = 4;
    localparam int DLY_W   = 16;
    localparam int BURST_W = 8;
    localparam int TMO_W   = 24;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: arm status, fires left (0 = continuous), first edge a rise is accepted, pulse timeline.
    bit m_arm   [NCH];
    int m_left  [NCH];
    int m_ready [NCH];
    int exp_q   [NCH][$];

    soft_event_trig_multi_if #(.NCH(NCH), .DLY_W(DLY_W), .BURST_W(BURST_W), .TMO_W(TMO_W)) bus ();

    soft_event_trig_multi #(.NCH(NCH), .DLY_W(DLY_W), .BURST_W(BURST_W), .TMO_W(TMO_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance to the next falling edge and compare trig_out with the predicted pulse timeline.
    task automatic tick();
        logic [NCH-1:0] ev;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        ev = '0;
        for (int c = 0; c < NCH; c++) begin
            if (exp_q[c].size() > 0 && exp_q[c][0] == cyc) begin
                ev[c] = 1'b1;
                void'(exp_q[c].pop_front());
            end
        end
        chk("trig_out", 32'(bus.trig_out), 32'(ev));
    endtask

    task automatic set_delay(int c, int d);
        bus.delay[c*DLY_W +: DLY_W] = DLY_W'(d);
    endtask

    task automatic arm(int c);
        bit got;
        got = 1'b0;
        bus.evg_soft_event[c] = 1'b1;
        tick();
        bus.evg_soft_event[c] = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.armed[c] === 1'b1) got = 1'b1;
        end
        chk("arm_wait", 32'(got), 32'd1);
        m_arm[c]   = 1'b1;
        m_left[c]  = int'(bus.burst_len);
        m_ready[c] = cyc + 1;
    endtask

    // Raise the trigger; it is sampled at the next edge k and, if usable, fires at k+delay.
    task automatic rise(int c);
        int k;
        int p;
        bus.evg_trig[c] = 1'b1;
        k = cyc + 1;
        if (m_arm[c] && bus.clk_enable && k >= m_ready[c]) begin
            p = k + int'(bus.delay[c*DLY_W +: DLY_W]);
            exp_q[c].push_back(p);
            m_ready[c] = p + 2;
            if (m_left[c] == 1) m_arm[c] = 1'b0;
            else if (m_left[c] > 1) m_left[c]--;
        end
    endtask

    task automatic drop(int c);
        bus.evg_trig[c] = 1'b0;
    endtask

    task automatic do_disarm(int c);
        bus.disarm[c] = 1'b1;
        while (exp_q[c].size() > 0 && exp_q[c][$] > cyc) void'(exp_q[c].pop_back());
        m_arm[c] = 1'b0;
        tick();
        bus.disarm[c] = 1'b0;
    endtask

    initial begin
        int c;
        reset              = 1'b0;
        bus.clk_enable     = 1'b1;
        bus.evg_soft_event = '0;
        bus.evg_trig       = '0;
        bus.disarm         = '0;
        bus.delay          = '0;
        bus.burst_len      = '0;
        bus.timeout        = '0;
        for (int i = 0; i < NCH; i++) begin
            m_arm[i]   = 1'b0;
            m_left[i]  = 0;
            m_ready[i] = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_trig_out", 32'(bus.trig_out), 32'd0);
        chk("rst_armed", 32'(bus.armed), 32'd0);
        chk("rst_timeout_flag", 32'(bus.timeout_flag), 32'd0);
        reset = 1'b1;

        // ch0: zero delay, single fire
        set_delay(0, 0);
        bus.burst_len = BURST_W'(1);
        arm(0);
        rise(0);
        tick();
        chk("ch0_armed_in_fire", 32'(bus.armed[0]), 32'd1);
        drop(0);
        tick();
        chk("ch0_idle_after", 32'(bus.armed[0]), 32'd0);

        // ch1: delay 10, burst 3, stray soft event while armed must not re-arm
        set_delay(1, 10);
        bus.burst_len = BURST_W'(3);
        arm(1);
        for (int i = 0; i < 3; i++) begin
            rise(1);
            tick();
            drop(1);
            tick();
            bus.evg_soft_event[1] = 1'b1;
            tick();
            bus.evg_soft_event[1] = 1'b0;
            repeat (17) tick();
            if (i < 2) chk("ch1_armed_mid", 32'(bus.armed[1]), 32'd1);
        end
        chk("ch1_idle_after_burst", 32'(bus.armed[1]), 32'd0);
        rise(1);
        repeat (15) tick();
        drop(1);
        tick();

        // ch3: continuous, held trigger, disarm in DELAY, soft event together with disarm
        set_delay(3, 4);
        bus.burst_len = BURST_W'(0);
        arm(3);
        for (int i = 0; i < 5; i++) begin
            rise(3);
            tick();
            drop(3);
            repeat (9) tick();
        end
        chk("ch3_cont_armed", 32'(bus.armed[3]), 32'd1);
        rise(3);
        repeat (30) tick();
        drop(3);
        tick();
        chk("ch3_held_armed", 32'(bus.armed[3]), 32'd1);
        rise(3);
        repeat (2) tick();
        do_disarm(3);
        drop(3);
        repeat (8) tick();
        chk("ch3_disarmed", 32'(bus.armed[3]), 32'd0);
        bus.disarm[3]         = 1'b1;
        bus.evg_soft_event[3] = 1'b1;
        tick();
        bus.evg_soft_event[3] = 1'b0;
        repeat (8) tick();
        bus.disarm[3] = 1'b0;
        repeat (4) tick();
        chk("ch3_sev_with_disarm", 32'(bus.armed[3]), 32'd0);

        // ch2: timeout, re-arm clears flag, clk_enable gap with held trigger
        bus.timeout = TMO_W'(100);
        set_delay(2, 3);
        bus.burst_len = BURST_W'(1);
        arm(2);
        repeat (99) tick();
        chk("ch2_armed_99", 32'(bus.armed[2]), 32'd1);
        chk("ch2_flag_99", 32'(bus.timeout_flag[2]), 32'd0);
        tick();
        chk("ch2_armed_100", 32'(bus.armed[2]), 32'd0);
        chk("ch2_flag_100", 32'(bus.timeout_flag[2]), 32'd1);
        m_arm[2] = 1'b0;
        arm(2);
        chk("ch2_rearm_flag_clr", 32'(bus.timeout_flag[2]), 32'd0);
        repeat (20) tick();
        bus.clk_enable = 1'b0;
        rise(2);
        repeat (50) tick();
        bus.clk_enable = 1'b1;
        repeat (79) tick();
        chk("ch2_gap_armed", 32'(bus.armed[2]), 32'd1);
        tick();
        chk("ch2_gap_expire", 32'(bus.armed[2]), 32'd0);
        chk("ch2_gap_flag", 32'(bus.timeout_flag[2]), 32'd1);
        m_arm[2] = 1'b0;
        drop(2);
        bus.timeout = TMO_W'(10);
        set_delay(2, 0);
        tick();
        arm(2);
        repeat (9) tick();
        rise(2);
        tick();
        drop(2);
        tick();
        chk("ch2_trig_beats_tmo_flag", 32'(bus.timeout_flag[2]), 32'd0);
        chk("ch2_trig_beats_tmo_idle", 32'(bus.armed[2]), 32'd0);
        bus.timeout = '0;

        // Randomized trigger trains against the timeline model
        for (int it = 0; it < 8; it++) begin
            c = int'($urandom_range(0, NCH-1));
            set_delay(c, int'($urandom_range(0, 12)));
            bus.burst_len = BURST_W'($urandom_range(0, 4));
            arm(c);
            for (int r = 0; r < 6; r++) begin
                repeat ($urandom_range(1, 20)) tick();
                set_delay(c, int'($urandom_range(0, 12)));
                rise(c);
                repeat ($urandom_range(1, 15)) tick();
                drop(c);
            end
            repeat (30) tick();
            chk("rnd_armed", 32'(bus.armed[c]), 32'(m_arm[c]));
            do_disarm(c);
            tick();
        end

        // ch0 timeout with a shorter limit, then reset in the middle of a ch1 delay
        bus.timeout   = TMO_W'(30);
        bus.burst_len = BURST_W'(1);
        arm(0);
        repeat (30) tick();
        chk("ch0_tmo30_flag", 32'(bus.timeout_flag[0]), 32'd1);
        chk("ch0_tmo30_idle", 32'(bus.armed[0]), 32'd0);
        m_arm[0]    = 1'b0;
        bus.timeout = '0;
        set_delay(1, 20);
        arm(1);
        rise(1);
        tick();
        drop(1);
        repeat (15) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_trig_out", 32'(bus.trig_out), 32'd0);
        chk("mid_rst_armed", 32'(bus.armed), 32'd0);
        chk("mid_rst_flag", 32'(bus.timeout_flag), 32'd0);
        for (int i = 0; i < NCH; i++) begin
            exp_q[i].delete();
            m_arm[i] = 1'b0;
        end
        repeat (2) tick();
        reset = 1'b1;
        repeat (12) tick();
        chk("post_rst_armed", 32'(bus.armed), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
